// File: rtl/conv_mdc_job_sched_pkg.sv
// Shared types for the conv_mdc job scheduler: descriptor layout, FSM states, queue depth.
// Descriptor field widths match the scheduler's default ADDR_W/CNT_W.
package conv_mdc_package;

    localparam int CONV_MDC_ADDR_W       = 32;
    localparam int CONV_MDC_CNT_W        = 16;
    localparam int CONV_MDC_SCHED_QDEPTH = 4;

    typedef struct packed {
        logic [CONV_MDC_ADDR_W-1:0] src_base;
        logic [CONV_MDC_ADDR_W-1:0] dst_base;
        logic [CONV_MDC_ADDR_W-1:0] src_stride;
        logic [CONV_MDC_ADDR_W-1:0] dst_stride;
        logic [CONV_MDC_CNT_W-1:0]  n_tiles;
    } job_desc_t;

    typedef enum logic [2:0] {
        SCHED_IDLE,
        SCHED_LOAD,
        SCHED_ISSUE,
        SCHED_RUN,
        SCHED_NEXT
    } state_sched_t;

endpackage

// File: rtl/conv_mdc_job_sched_if.sv
// Job descriptor channel into the scheduler (valid/ready).
// Master drives the descriptor; the scheduler (slave) returns ready.
interface conv_mdc_job_sched_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              job_valid_i;
    logic              job_ready_o;
    logic [ADDR_W-1:0] job_src_base_i;
    logic [ADDR_W-1:0] job_dst_base_i;
    logic [ADDR_W-1:0] job_src_stride_i;
    logic [ADDR_W-1:0] job_dst_stride_i;
    logic [CNT_W-1:0]  job_n_tiles_i;

    modport master (
        output job_valid_i, job_src_base_i, job_dst_base_i,
               job_src_stride_i, job_dst_stride_i, job_n_tiles_i,
        input  job_ready_o
    );

    modport slave (
        input  job_valid_i, job_src_base_i, job_dst_base_i,
               job_src_stride_i, job_dst_stride_i, job_n_tiles_i,
        output job_ready_o
    );
endinterface

// File: rtl/conv_mdc_job_fifo.sv
// QDEPTH-entry descriptor queue; head visible combinationally, count updates one cycle after push/pop.
// Push while full and pop while empty are dropped; clear empties the queue like reset.
module conv_mdc_job_fifo
    import conv_mdc_package::*;
#(
    parameter  int QDEPTH = CONV_MDC_SCHED_QDEPTH,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  job_desc_t     desc_i,
    input  logic          pop_i,
    output job_desc_t     desc_o,
    output logic [CW-1:0] count_o
);

    job_desc_t     mem_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = push_i && (count_q < CW'(QDEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= desc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign desc_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/conv_mdc_job_sched.sv
// Queued job scheduler: walks each descriptor tile by tile, pulsing start and waiting done per tile.
// Start 3 cycles after accept into an empty idle queue, 2 cycles done->start; ready drops when queue full.
module conv_mdc_job_sched
    import conv_mdc_package::*;
#(
    parameter  int ADDR_W = CONV_MDC_ADDR_W,
    parameter  int CNT_W  = CONV_MDC_CNT_W,
    parameter  int QDEPTH = CONV_MDC_SCHED_QDEPTH,
    localparam int CW     = $clog2(QDEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    conv_mdc_job_sched_if.slave   job,
    output logic                  fsm_start_o,
    input  logic                  fsm_done_i,
    output logic [ADDR_W-1:0]     src_addr_o,
    output logic [ADDR_W-1:0]     dst_addr_o,
    output logic [CNT_W-1:0]      tile_idx_o,
    output logic                  busy_o,
    output logic                  job_done_evt_o,
    output logic [CW-1:0]         q_count_o
);

    state_sched_t      state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [ADDR_W-1:0] src_stride_q, src_stride_d, dst_stride_q, dst_stride_d;
    logic [CNT_W-1:0]  idx_q, idx_d, n_tiles_q, n_tiles_d;
    logic              evt_q, evt_d;
    logic              ready_en_q;
    logic              push, pop;
    logic [CW-1:0]     q_count;
    job_desc_t         desc_in, head;

    assign desc_in = '{src_base:   job.job_src_base_i,
                       dst_base:   job.job_dst_base_i,
                       src_stride: job.job_src_stride_i,
                       dst_stride: job.job_dst_stride_i,
                       n_tiles:    job.job_n_tiles_i};

    // Ready is held low for the first cycle out of reset/clear.
    assign job.job_ready_o = ready_en_q && (q_count < CW'(QDEPTH));
    assign push            = job.job_valid_i && job.job_ready_o;

    conv_mdc_job_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .desc_i  (desc_in),
        .pop_i   (pop),
        .desc_o  (head),
        .count_o (q_count)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        idx_d        = idx_q;
        src_stride_d = src_stride_q;
        dst_stride_d = dst_stride_q;
        n_tiles_d    = n_tiles_q;
        evt_d        = 1'b0;
        pop          = 1'b0;
        case (state_q)
            SCHED_IDLE: begin
                if (q_count != '0) begin
                    pop          = 1'b1;
                    src_d        = head.src_base;
                    dst_d        = head.dst_base;
                    src_stride_d = head.src_stride;
                    dst_stride_d = head.dst_stride;
                    n_tiles_d    = head.n_tiles;
                    idx_d        = '0;
                    state_d      = SCHED_LOAD;
                end
            end
            SCHED_LOAD: begin
                if (n_tiles_q == '0) begin
                    evt_d   = 1'b1;
                    state_d = SCHED_IDLE;
                end else begin
                    state_d = SCHED_ISSUE;
                end
            end
            SCHED_ISSUE: state_d = SCHED_RUN;
            SCHED_RUN: begin
                if (fsm_done_i) begin
                    if (idx_q == n_tiles_q - CNT_W'(1)) begin
                        evt_d   = 1'b1;
                        state_d = SCHED_IDLE;
                    end else begin
                        state_d = SCHED_NEXT;
                    end
                end
            end
            SCHED_NEXT: begin
                idx_d   = idx_q + CNT_W'(1);
                src_d   = src_q + src_stride_q;
                dst_d   = dst_q + dst_stride_q;
                state_d = SCHED_ISSUE;
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q      <= SCHED_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            idx_q        <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            n_tiles_q    <= '0;
            evt_q        <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            idx_q        <= idx_d;
            src_stride_q <= src_stride_d;
            dst_stride_q <= dst_stride_d;
            n_tiles_q    <= n_tiles_d;
            evt_q        <= evt_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign fsm_start_o    = (state_q == SCHED_ISSUE);
    assign busy_o         = (state_q != SCHED_IDLE);
    assign job_done_evt_o = evt_q;
    assign src_addr_o     = src_q;
    assign dst_addr_o     = dst_q;
    assign tile_idx_o     = idx_q;
    assign q_count_o      = q_count;

endmodule

// File: tb/tb_conv_mdc_job_sched.sv
// Scoreboard bench for conv_mdc_job_sched: directed jobs, expected starts/events queued, monitor compares.
module tb_conv_mdc_job_sched;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        fsm_start;
    logic        fsm_done;
    logic        resp_done;
    logic        man_done;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] tile_idx;
    logic        busy, evt;
    logic [2:0]  q_count;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    int n_events = 0;
    bit resp_en = 0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] idx;
        int          cyc;
    } st_exp_t;

    typedef struct {
        logic [31:0] src;
        int          cyc;
    } ev_exp_t;

    st_exp_t sq[$];
    ev_exp_t eq[$];

    conv_mdc_job_sched_if #(.ADDR_W(32), .CNT_W(16)) job_if ();

    assign fsm_done = resp_done | man_done;

    conv_mdc_job_sched dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .job            (job_if),
        .fsm_start_o    (fsm_start),
        .fsm_done_i     (fsm_done),
        .src_addr_o     (src_addr),
        .dst_addr_o     (dst_addr),
        .tile_idx_o     (tile_idx),
        .busy_o         (busy),
        .job_done_evt_o (evt),
        .q_count_o      (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_start(logic [31:0] s, logic [31:0] d, logic [15:0] i, int c);
        st_exp_t e;
        e.src = s; e.dst = d; e.idx = i; e.cyc = c;
        sq.push_back(e);
    endtask

    task automatic exp_evt(logic [31:0] s, int c);
        ev_exp_t e;
        e.src = s; e.cyc = c;
        eq.push_back(e);
    endtask

    // Called at #1 after a posedge; valid is held for exactly one cycle.
    task automatic push_job(logic [31:0] sb, logic [31:0] db, logic [31:0] ss,
                            logic [31:0] ds, logic [15:0] n);
        job_if.job_valid_i      = 1'b1;
        job_if.job_src_base_i   = sb;
        job_if.job_dst_base_i   = db;
        job_if.job_src_stride_i = ss;
        job_if.job_dst_stride_i = ds;
        job_if.job_n_tiles_i    = n;
        @(posedge clk);
        #1;
        job_if.job_valid_i = 1'b0;
    endtask

    task automatic wait_starts(int target, int limit);
        int k = 0;
        while (n_starts < target && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("wait_start_timeout", 64'(n_starts >= target), 64'd1);
    endtask

    task automatic wait_events(int target, int limit);
        int k = 0;
        while (n_events < target && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("wait_event_timeout", 64'(n_events >= target), 64'd1);
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        @(posedge clk);
        #1;
        man_done = 1'b0;
    endtask

    initial begin
        int p;
        int ev0;
        int st0;
        rst_n = 1'b0;
        clear = 1'b0;
        man_done = 1'b0;
        resp_done = 1'b0;
        job_if.job_valid_i = 1'b0;
        job_if.job_src_base_i = '0;
        job_if.job_dst_base_i = '0;
        job_if.job_src_stride_i = '0;
        job_if.job_dst_stride_i = '0;
        job_if.job_n_tiles_i = '0;

        fork
            forever begin
                @(negedge clk);
                if (fsm_start === 1'b1) begin
                    n_starts++;
                    checks++;
                    if (sq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_start: src %0h idx %0d cycle %0d", src_addr, tile_idx, cyc);
                    end else begin
                        st_exp_t e;
                        e = sq.pop_front();
                        if (src_addr !== e.src || dst_addr !== e.dst || tile_idx !== e.idx ||
                            (e.cyc >= 0 && cyc != e.cyc)) begin
                            errors++;
                            $display("FAIL start: got src %0h dst %0h idx %0d cyc %0d expected src %0h dst %0h idx %0d cyc %0d",
                                     src_addr, dst_addr, tile_idx, cyc, e.src, e.dst, e.idx, e.cyc);
                        end
                    end
                end
                if (evt === 1'b1) begin
                    n_events++;
                    checks++;
                    if (eq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: src %0h cycle %0d", src_addr, cyc);
                    end else begin
                        ev_exp_t e;
                        e = eq.pop_front();
                        if (src_addr !== e.src || (e.cyc >= 0 && cyc != e.cyc)) begin
                            errors++;
                            $display("FAIL event: got src %0h cyc %0d expected src %0h cyc %0d",
                                     src_addr, cyc, e.src, e.cyc);
                        end
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (resp_en && fsm_start === 1'b1) begin
                    repeat (5) @(posedge clk);
                    #1 resp_done = 1'b1;
                    @(posedge clk);
                    #1 resp_done = 1'b0;
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", 64'(fsm_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_evt", 64'(evt), 64'd0);
        check("rst_qcount", 64'(q_count), 64'd0);
        check("rst_src", 64'(src_addr), 64'd0);
        check("rst_ready", 64'(job_if.job_ready_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'(job_if.job_ready_o), 64'd1);

        // Test 1: three tiles, done 5 cycles after each start
        resp_en = 1;
        p = cyc;
        exp_start(32'h1000, 32'h2000, 16'd0, p + 3);
        exp_start(32'h1100, 32'h2080, 16'd1, p + 10);
        exp_start(32'h1200, 32'h2100, 16'd2, p + 17);
        exp_evt(32'h1200, p + 23);
        push_job(32'h1000, 32'h2000, 32'h100, 32'h80, 16'd3);
        wait_events(1, 60);
        repeat (3) @(posedge clk);
        #1;
        check("t1_idle", 64'(busy), 64'd0);

        // Test 2: five back-to-back single-tile jobs, manual done
        resp_en = 0;
        st0 = n_starts;
        ev0 = n_events;
        for (int k = 0; k < 5; k++) begin
            exp_start(32'hA000 + 32'(k) * 32'h10, 32'hE000 + 32'(k) * 32'h10, 16'd0, -1);
            exp_evt(32'hA000 + 32'(k) * 32'h10, -1);
        end
        for (int k = 0; k < 5; k++)
            push_job(32'hA000 + 32'(k) * 32'h10, 32'hE000 + 32'(k) * 32'h10, 32'h0, 32'h0, 16'd1);
        check("t2_qcount_full", 64'(q_count), 64'd4);
        check("t2_ready_low", 64'(job_if.job_ready_o), 64'd0);
        push_job(32'hDEAD0000, 32'hDEAD0000, 32'h0, 32'h0, 16'd1);
        check("t2_push_when_full", 64'(q_count), 64'd4);
        for (int k = 0; k < 5; k++) begin
            wait_starts(st0 + k + 1, 40);
            repeat (2) @(posedge clk);
            #1;
            pulse_done();
        end
        wait_events(ev0 + 5, 20);
        check("t2_qcount_empty", 64'(q_count), 64'd0);

        // Test 3: empty job followed by a two-tile job
        resp_en = 1;
        ev0 = n_events;
        exp_evt(32'hB000, -1);
        exp_start(32'hC000, 32'hD000, 16'd0, -1);
        exp_start(32'hC040, 32'hD020, 16'd1, -1);
        exp_evt(32'hC040, -1);
        push_job(32'hB000, 32'hB800, 32'h10, 32'h10, 16'd0);
        push_job(32'hC000, 32'hD000, 32'h40, 32'h20, 16'd2);
        wait_events(ev0 + 2, 60);

        // Test 4: source address wraps past 2^32
        ev0 = n_events;
        exp_start(32'hFFFF_FF80, 32'h0, 16'd0, -1);
        exp_start(32'h0000_0080, 32'h10, 16'd1, -1);
        exp_evt(32'h0000_0080, -1);
        push_job(32'hFFFF_FF80, 32'h0, 32'h100, 32'h10, 16'd2);
        wait_events(ev0 + 1, 60);

        // Test 5: done in IDLE and in ISSUE is ignored
        resp_en = 0;
        repeat (2) @(posedge clk);
        #1;
        ev0 = n_events;
        pulse_done();
        repeat (3) @(posedge clk);
        #1;
        check("t5_idle_done_busy", 64'(busy), 64'd0);
        exp_start(32'h5000, 32'h6000, 16'd0, -1);
        exp_evt(32'h5000, -1);
        push_job(32'h5000, 32'h6000, 32'h0, 32'h0, 16'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t5_in_issue", 64'(fsm_start), 64'd1);
        pulse_done();
        repeat (4) @(posedge clk);
        #1;
        check("t5_still_run", 64'(busy), 64'd1);
        check("t5_no_event", 64'(n_events - ev0), 64'd0);
        pulse_done();
        wait_events(ev0 + 1, 10);

        // Test 6: reset during tile 1 of 3 with two jobs queued
        st0 = n_starts;
        ev0 = n_events;
        exp_start(32'h3000, 32'h4000, 16'd0, -1);
        exp_start(32'h3010, 32'h4008, 16'd1, -1);
        push_job(32'h3000, 32'h4000, 32'h10, 32'h8, 16'd3);
        push_job(32'h7000, 32'h7000, 32'h0, 32'h0, 16'd1);
        push_job(32'h8000, 32'h8000, 32'h0, 32'h0, 16'd1);
        wait_starts(st0 + 1, 20);
        repeat (2) @(posedge clk);
        #1;
        pulse_done();
        wait_starts(st0 + 2, 20);
        check("t6_qcount_before", 64'(q_count), 64'd2);
        rst_n = 1'b0;
        man_done = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        man_done = 1'b0;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_qcount", 64'(q_count), 64'd0);
        check("t6_src", 64'(src_addr), 64'd0);
        check("t6_idx", 64'(tile_idx), 64'd0);
        check("t6_ready_low", 64'(job_if.job_ready_o), 64'd0);
        @(posedge clk);
        #1;
        check("t6_ready_back", 64'(job_if.job_ready_o), 64'd1);
        pulse_done();
        repeat (10) @(posedge clk);
        #1;
        check("t6_busy_after", 64'(busy), 64'd0);
        check("t6_no_event", 64'(n_events - ev0), 64'd0);

        check("start_q_drained", 64'(sq.size()), 64'd0);
        check("event_q_drained", 64'(eq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
